// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner: time-shares one seven-segment decoder
// across NUM_DIGITS common-anode digits, with frame-atomic value updates
// and optional leading-zero blanking.
module hex_display_scanner #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned TICK_DIV   = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic                    enable,
   input  logic                    blank_lz,
   output logic [3:0]              digit,
   output logic                    show,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]        r_pre;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_pend;
   logic                    r_pend_vld;
   logic [4*NUM_DIGITS-1:0] r_disp;
   logic                    r_wrap;
   logic [3:0]              r_digit;
   logic                    r_show;
   logic [NUM_DIGITS-1:0]   r_an;
   logic                    r_frame_done;

   logic                    w_tick;
   logic                    w_wrap;
   logic [3:0]              w_nib;
   logic [NUM_DIGITS-1:0]   w_sel_an;
   logic [NUM_DIGITS-1:0]   w_lead;
   logic                    w_zero_run;
   logic                    w_blank;

   assign w_tick = enable && (r_pre == LAST_PRE);
   assign w_wrap = w_tick && (r_idx == LAST_IDX);

   // Digit mux, anode decode and leading-zero detection for the current index
   always_comb begin
      w_nib      = 4'h0;
      w_sel_an   = '1;
      w_lead     = '0;
      w_zero_run = 1'b1;
      w_blank    = 1'b0;
      // w_lead[i]: nibbles NUM_DIGITS-1 down to i are all zero
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run & (r_disp[4*i +: 4] == 4'h0);
         w_lead[i]  = w_zero_run;
      end
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib       = r_disp[4*i +: 4];
            w_sel_an[i] = 1'b0;
            w_blank     = blank_lz && (i != 0) && w_lead[i];
         end
      end
   end

   // Prescaler, scan index, pending capture and frame-atomic display update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pre      <= '0;
         r_idx      <= '0;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_disp     <= '0;
         r_wrap     <= 1'b0;
      end else begin
         if (enable) begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
         end
         if (w_tick) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
         end
         if (load) begin
            r_pend     <= value;
            r_pend_vld <= 1'b1;
         end
         if (w_wrap) begin
            // A load coinciding with the wrap goes straight to the display
            r_pend_vld <= 1'b0;
            if (load) begin
               r_disp <= value;
            end else if (r_pend_vld) begin
               r_disp <= r_pend;
            end
         end
         // Delayed so frame_done lines up with the first index-0 output cycle
         r_wrap <= w_wrap;
      end
   end

   // Registered outputs; the display goes dark while scanning is disabled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_digit      <= 4'h0;
         r_show       <= 1'b0;
         r_an         <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_digit      <= w_nib;
         r_show       <= enable && !w_blank;
         r_an         <= enable ? w_sel_an : '1;
         r_frame_done <= enable && r_wrap;
      end
   end

   assign digit      = r_digit;
   assign show       = r_show;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed self-checking bench for hex_display_scanner (4 digits, 4-cycle dwell).
module tb_hex_display_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = 16'h0;
   logic        load = 1'b0;
   logic        enable = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  digit;
   logic        show;
   logic [3:0]  an;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;

   hex_display_scanner #(
      .NUM_DIGITS (4),
      .TICK_DIV   (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .load       (load),
      .enable     (enable),
      .blank_lz   (blank_lz),
      .digit      (digit),
      .show       (show),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until frame_done is seen, bounded
   task automatic wait_fd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; load = 1'b0;
      step(); step();
      n_cmp++; if (an !== 4'b1111) begin n_err++; $display("FAIL reset_an got %b want 1111", an); end
      n_cmp++; if (show !== 1'b0) begin n_err++; $display("FAIL reset_show got %b want 0", show); end
      n_cmp++; if (digit !== 4'h0) begin n_err++; $display("FAIL reset_digit got %h want 0", digit); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got %b want 0", frame_done); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      bit          ok;
      logic [15:0] v;
      logic [3:0]  exp_d;
      logic [3:0]  exp_an;
      v = 16'h1234;
      enable = 1'b1; value = v; load = 1'b1;
      step();
      load = 1'b0;
      wait_fd(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_fd_timeout got 0 want 1"); end
      for (int k = 0; k < 16; k++) begin
         if (k > 0) step();
         exp_d  = v[4*(k/4) +: 4];
         exp_an = ~(4'b0001 << (k/4));
         n_cmp++; if (digit !== exp_d) begin n_err++; $display("FAIL basic_digit k=%0d got %h want %h", k, digit, exp_d); end
         n_cmp++; if (an !== exp_an) begin n_err++; $display("FAIL basic_an k=%0d got %b want %b", k, an, exp_an); end
         n_cmp++; if (show !== 1'b1) begin n_err++; $display("FAIL basic_show k=%0d got %b want 1", k, show); end
         n_cmp++; if (frame_done !== (k == 0)) begin n_err++; $display("FAIL basic_fd k=%0d got %b want %b", k, frame_done, k == 0); end
      end
   endtask

   task automatic test_blank();
      bit         ok;
      logic [3:0] exp_show;
      blank_lz = 1'b1;
      for (int t = 0; t < 2; t++) begin
         value    = (t == 0) ? 16'h0050 : 16'h0000;
         exp_show = (t == 0) ? 4'b0011 : 4'b0001;
         load = 1'b1;
         step();
         load = 1'b0;
         wait_fd(ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL blank_fd_timeout t=%0d got 0 want 1", t); end
         for (int d = 0; d < 4; d++) begin
            if (d > 0) begin step(); step(); step(); step(); end
            n_cmp++; if (an !== ~(4'b0001 << d)) begin n_err++; $display("FAIL blank_an t=%0d d=%0d got %b want %b", t, d, an, ~(4'b0001 << d)); end
            n_cmp++; if (show !== exp_show[d]) begin n_err++; $display("FAIL blank_show t=%0d d=%0d got %b want %b", t, d, show, exp_show[d]); end
            n_cmp++; if (digit !== value[4*d +: 4]) begin n_err++; $display("FAIL blank_digit t=%0d d=%0d got %h want %h", t, d, digit, value[4*d +: 4]); end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      wait_fd(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_fd_timeout got 0 want 1"); end
      // Display holds 0000; loads land at index 1 and index 2
      for (int s = 1; s <= 15; s++) begin
         if (s == 5) begin value = 16'hAAAA; load = 1'b1; end
         if (s == 9) begin value = 16'hBBBB; load = 1'b1; end
         step();
         load = 1'b0;
         n_cmp++; if (digit !== 4'h0) begin n_err++; $display("FAIL b2b_old_digit s=%0d got %h want 0", s, digit); end
      end
      step();
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL b2b_fd got %b want 1", frame_done); end
      for (int d = 0; d < 4; d++) begin
         if (d > 0) begin step(); step(); step(); step(); end
         n_cmp++; if (digit !== 4'hB) begin n_err++; $display("FAIL b2b_new_digit d=%0d got %h want b", d, digit); end
         n_cmp++; if (an !== ~(4'b0001 << d)) begin n_err++; $display("FAIL b2b_an d=%0d got %b want %b", d, an, ~(4'b0001 << d)); end
      end
   endtask

   task automatic test_wrap_load();
      bit ok;
      int pulses;
      wait_fd(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_fd_timeout got 0 want 1"); end
      repeat (14) step();
      value = 16'hCCCC; load = 1'b1;
      step();
      load = 1'b0;
      n_cmp++; if (digit !== 4'hB || an !== 4'b0111) begin n_err++; $display("FAIL wrap_last_old got %h/%b want b/0111", digit, an); end
      pulses = 0;
      for (int s = 0; s < 15; s++) begin
         step();
         if (frame_done === 1'b1) pulses++;
         if (s == 0) begin
            n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL wrap_fd got %b want 1", frame_done); end
         end
         n_cmp++; if (digit !== 4'hC) begin n_err++; $display("FAIL wrap_digit s=%0d got %h want c", s, digit); end
      end
      n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL wrap_pulses got %0d want 1", pulses); end
   endtask

   task automatic test_enable();
      bit ok;
      wait_fd(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL en_fd_timeout got 0 want 1"); end
      repeat (8) step();
      n_cmp++; if (an !== 4'b1011) begin n_err++; $display("FAIL en_pre_an got %b want 1011", an); end
      enable = 1'b0;
      for (int s = 0; s < 10; s++) begin
         step();
         n_cmp++; if (an !== 4'b1111 || show !== 1'b0 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL en_frozen s=%0d got an=%b show=%b fd=%b want 1111/0/0", s, an, show, frame_done);
         end
      end
      enable = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step();
         n_cmp++; if (an !== 4'b1011 || digit !== 4'hC || show !== 1'b1) begin
            n_err++; $display("FAIL en_resume s=%0d got an=%b d=%h show=%b want 1011/c/1", s, an, digit, show);
         end
      end
      step();
      n_cmp++; if (an !== 4'b0111) begin n_err++; $display("FAIL en_next_an got %b want 0111", an); end
      for (int s = 0; s < 4; s++) begin
         step();
         n_cmp++; if (frame_done !== (s == 3)) begin n_err++; $display("FAIL en_fd s=%0d got %b want %b", s, frame_done, s == 3); end
      end
      n_cmp++; if (an !== 4'b1110) begin n_err++; $display("FAIL en_wrap_an got %b want 1110", an); end
   endtask

   task automatic test_reset_midframe();
      repeat (5) step();
      rst_n = 1'b0; load = 1'b1; value = 16'hDDDD; enable = 1'b1;
      step();
      n_cmp++; if (an !== 4'b1111 || show !== 1'b0 || digit !== 4'h0 || frame_done !== 1'b0) begin
         n_err++; $display("FAIL rstmid_out got an=%b show=%b d=%h fd=%b want 1111/0/0/0", an, show, digit, frame_done);
      end
      rst_n = 1'b1; load = 1'b0;
      for (int s = 1; s <= 17; s++) begin
         step();
         n_cmp++; if (frame_done !== (s == 17)) begin n_err++; $display("FAIL rstmid_fd s=%0d got %b want %b", s, frame_done, s == 17); end
      end
      n_cmp++; if (digit !== 4'h0 || an !== 4'b1110) begin n_err++; $display("FAIL rstmid_disp got %h/%b want 0/1110", digit, an); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blank();
      test_back_to_back();
      test_wrap_load();
      test_enable();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
